vertical_vga: RTL
=================

Name: vertical_vga

Overview:
- Vertical timing stage for the 640x480 VGA driver. It sits directly downstream of the horizontal timing generator and consumes that block's HSYNC output.
- Counts scan lines from HSYNC rising edges and generates VSYNC, the BRAM row address VPIXEL and a vertical display-enable.
- Each BRAM row is shown on 5 consecutive scan lines (96 rows x 5 = 480 lines), matching the 5x horizontal pixel repeat.
- Its outputs feed the BRAM read address and the final RGB gating (RGB = horizontal rgb AND vrgb).

Parameters:
DISP_LINES, 480, visible lines per frame
FP_LINES, 10, front porch lines
SYNC_LINES, 2, VSYNC pulse lines
BP_LINES, 29, back porch lines (frame = 521 lines)
LINE_REPEAT, 5, scan lines per BRAM row
ROWS, 96, BRAM rows (DISP_LINES / LINE_REPEAT)

Ports:
clk  input  1  system clock, same clock as the horizontal stage
reset  input  1  synchronous, active-high reset
HSYNC  input  1  active-low horizontal sync from the horizontal stage
VPIXEL  output  7  BRAM row address, 0..ROWS-1
VSYNC  output  1  active-low vertical sync
vrgb  output  1  1 = vertical display window
frame_start  output  1  one-cycle pulse at the first display line of a frame

Behaviour:
- All logic is clocked on posedge clk. Reset is synchronous and has priority over every other condition.
- Reset values:
  - state = DISPLAY, line_counter = 0, repeat_counter = 0.
  - VPIXEL = 0, VSYNC = 1, vrgb = 1, frame_start = 0.
  - hsync_d = 1, so no tick is produced straight out of reset.
- Line tick:
  - hsync_d registers HSYNC every cycle.
  - line_tick = HSYNC & ~hsync_d, i.e. the rising edge, meaning end of the horizontal sync pulse.
  - The line boundary is defined at this edge. Exactly one tick per line.
- Latency: every output is registered. A change caused by a tick is visible on the cycle after the cycle in which line_tick = 1. With no tick, all state and outputs hold.
- FSM states: DISPLAY, FRONT_PORCH, SYNC_PULSE, BACK_PORCH.
- line_counter (10 bit) counts ticks within the current state. It is cleared on every state change.
- DISPLAY state:
  - vrgb = 1, VSYNC = 1.
  - On a tick, repeat_counter increments. When repeat_counter = LINE_REPEAT-1, it is cleared and VPIXEL increments.
  - On the tick with line_counter = DISP_LINES-1, the FSM moves to FRONT_PORCH; VPIXEL and repeat_counter are cleared to 0.
  - VPIXEL never exceeds ROWS-1 (95) and never wraps through 127.
- FRONT_PORCH state:
  - vrgb = 0, VSYNC = 1.
  - On the tick with line_counter = FP_LINES-1, the FSM moves to SYNC_PULSE.
- SYNC_PULSE state:
  - vrgb = 0, VSYNC = 0.
  - On the tick with line_counter = SYNC_LINES-1, the FSM moves to BACK_PORCH.
- BACK_PORCH state:
  - vrgb = 0, VSYNC = 1.
  - On the tick with line_counter = BP_LINES-1, the FSM moves to DISPLAY and frame_start = 1 for exactly one cycle.
  - VPIXEL is already 0 at this point.
- VSYNC and vrgb are decoded from the registered next state, so they change on the same edge as the state.
- Reset mid-frame: the block returns to the DISPLAY line 0 / VPIXEL 0 condition on the next edge. No frame_start is produced for this forced restart.
- HSYNC held constantly low or high produces no ticks. The block holds its state indefinitely and has no timeout.
- A glitch (high then low, one cycle each) counts as one line. The upstream stage guarantees a clean HSYNC.

Decomposition:
- Shared package holds:
  - the state encodings (2 bit, same codes as the horizontal stage: 00 display, 01 front porch, 10 sync, 11 back porch);
  - the timing constants for DISP_LINES, FP_LINES, SYNC_LINES, BP_LINES, LINE_REPEAT and ROWS.
- One natural sub-module: vga_edge_detect. It holds the hsync_d register and produces line_tick (rising-edge pulse, synchronous reset to 1).

Test Plan:
- Reset, then drive HSYNC with low 2 / high 8 cycles per line (fast line, block only sees edges) -> VPIXEL = 0, vrgb = 1, VSYNC = 1; VPIXEL = 1 after the 5th tick; VPIXEL = 95 after the 475th tick.
- Continue to tick 480 -> vrgb = 0, VPIXEL = 0, VSYNC = 1. After tick 490, VSYNC = 0 for exactly 2 lines. VSYNC returns to 1 after tick 492.
- Continue to tick 521 -> frame_start high for exactly 1 cycle, vrgb = 1, VPIXEL = 0. Then run a second frame: identical counts, period 521 ticks.
- Assert reset for 1 cycle while in SYNC_PULSE (VSYNC = 0) -> next cycle VSYNC = 1, vrgb = 1, VPIXEL = 0, frame_start = 0. Counting restarts from line 0.
- Hold HSYNC = 1 for 10000 cycles mid-display, then resume -> no output changes during the hold; counting resumes where it stopped.
- Connect horizontal_vga with default timing (3200-cycle line) -> VSYNC period = 521 x 3200 = 1,667,200 cycles; VSYNC low for 6400 cycles.

Source files
------------

// File: rtl/vertical_vga_pkg.sv
// Shared state encodings and vertical timing constants for the 640x480 VGA driver.
// State codes are the same as in the horizontal stage so debug views line up.
package vertical_vga_pkg;

  typedef enum logic [1:0] {
    ST_DISPLAY     = 2'b00,
    ST_FRONT_PORCH = 2'b01,
    ST_SYNC_PULSE  = 2'b10,
    ST_BACK_PORCH  = 2'b11
  } vga_state_e;

  localparam int unsigned DISP_LINES  = 480;
  localparam int unsigned FP_LINES    = 10;
  localparam int unsigned SYNC_LINES  = 2;
  localparam int unsigned BP_LINES    = 29;
  localparam int unsigned LINE_REPEAT = 5;
  localparam int unsigned ROWS        = DISP_LINES / LINE_REPEAT;

  localparam int unsigned LINE_W = 10;
  localparam int unsigned REP_W  = 3;
  localparam int unsigned ROW_W  = 7;

  // Terminal counts, pre-sized to the counter widths they are compared against.
  localparam logic [LINE_W-1:0] DISP_LAST = LINE_W'(DISP_LINES - 1);
  localparam logic [LINE_W-1:0] FP_LAST   = LINE_W'(FP_LINES - 1);
  localparam logic [LINE_W-1:0] SYNC_LAST = LINE_W'(SYNC_LINES - 1);
  localparam logic [LINE_W-1:0] BP_LAST   = LINE_W'(BP_LINES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(LINE_REPEAT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

endpackage

// File: rtl/vga_edge_detect.sv
// Rising-edge detector on the horizontal sync; one pulse marks the end of each line.
// The history flop resets high so a sync already high at reset release gives no pulse.
module vga_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic rise
);

  logic sync_d;
  logic sync_q;

  always_comb begin
    sync_d = sync_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_in & ~sync_q;

endmodule

// File: rtl/vertical_vga.sv
// Vertical timing stage: counts lines from HSYNC rising edges and produces VSYNC,
// the BRAM row address (each row repeated over several lines) and the display window.
module vertical_vga
  import vertical_vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             HSYNC,
  output logic [ROW_W-1:0] VPIXEL,
  output logic             VSYNC,
  output logic             vrgb,
  output logic             frame_start,
  output vga_state_e       state_dbg
);

  logic line_tick;

  vga_state_e        state_q, state_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [ROW_W-1:0]  vpixel_q, vpixel_d;
  logic              vsync_q, vsync_d;
  logic              vrgb_q, vrgb_d;
  logic              frame_start_q, frame_start_d;

  vga_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .sync_in (HSYNC),
    .rise    (line_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_DISPLAY;
      line_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      vpixel_q      <= '0;
      vsync_q       <= 1'b1;
      vrgb_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      vpixel_q      <= vpixel_d;
      vsync_q       <= vsync_d;
      vrgb_q        <= vrgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    vpixel_d      = vpixel_q;
    frame_start_d = 1'b0;

    if (line_tick) begin
      line_cnt_d = line_cnt_q + 1'b1;
      unique case (state_q)
        ST_DISPLAY: begin
          if (line_cnt_q == DISP_LAST) begin
            state_d    = ST_FRONT_PORCH;
            line_cnt_d = '0;
            rep_cnt_d  = '0;
            vpixel_d   = '0;
          end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            // Clamp keeps the row address inside the BRAM even if counts drift.
            if (vpixel_q != ROW_LAST) begin
              vpixel_d = vpixel_q + 1'b1;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        ST_FRONT_PORCH: begin
          if (line_cnt_q == FP_LAST) begin
            state_d    = ST_SYNC_PULSE;
            line_cnt_d = '0;
          end
        end
        ST_SYNC_PULSE: begin
          if (line_cnt_q == SYNC_LAST) begin
            state_d    = ST_BACK_PORCH;
            line_cnt_d = '0;
          end
        end
        ST_BACK_PORCH: begin
          if (line_cnt_q == BP_LAST) begin
            state_d       = ST_DISPLAY;
            line_cnt_d    = '0;
            frame_start_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_DISPLAY;
          line_cnt_d = '0;
        end
      endcase
    end

    // Decoded from the next state so sync/window move on the same edge as the FSM.
    vsync_d = (state_d != ST_SYNC_PULSE);
    vrgb_d  = (state_d == ST_DISPLAY);
  end

  assign VPIXEL      = vpixel_q;
  assign VSYNC       = vsync_q;
  assign vrgb        = vrgb_q;
  assign frame_start = frame_start_q;
  assign state_dbg   = state_q;

endmodule
